// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Packs instruction-class fields into RV32 words and writes them to
//            imem at an auto-incrementing address. Optional macro:
//            IMM_RANGE_CHECK_EN (reject out-of-range immediates).
// Revision : 1.0
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              busy
);

    localparam logic [2:0] C_CLS_R    = 3'd0;
    localparam logic [2:0] C_CLS_I    = 3'd1;
    localparam logic [2:0] C_CLS_LD   = 3'd2;
    localparam logic [2:0] C_CLS_ST   = 3'd3;
    localparam logic [2:0] C_CLS_BEQ  = 3'd4;
    localparam logic [2:0] C_CLS_JAL  = 3'd5;

    localparam logic [ADDR_W:0] C_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               err_q, err_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [2:0]         cls_q;
    logic [4:0]         rd_q, rs1_q, rs2_q;
    logic [2:0]         f3_q;
    logic [6:0]         f7_q;
    logic [31:0]        imm_q;

    logic               accept;
    logic [31:0]        enc_word;
    logic               cls_illegal;
    logic               imm_ok;

    // start takes priority over a request presented in the same cycle.
    assign req_ready = (state_q == S_IDLE) && !start;
    assign accept    = req_valid && req_ready;

    always_comb begin
        enc_word    = '0;
        cls_illegal = 1'b0;
        case (cls_q)
            C_CLS_R:   enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
            C_CLS_I:   enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
            C_CLS_LD:  enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
            C_CLS_ST:  enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
            C_CLS_BEQ: enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                                   imm_q[4:1], imm_q[11], 7'b1100011};
            C_CLS_JAL: enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                                   rd_q, 7'b1101111};
            default:   cls_illegal = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm_q;

    always_comb begin
        imm_ok = 1'b1;
        case (cls_q)
            C_CLS_I, C_CLS_LD, C_CLS_ST:
                imm_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            C_CLS_BEQ:
                imm_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm_q[0];
            C_CLS_JAL:
                imm_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm_q[0];
            default:
                imm_ok = 1'b1;
        endcase
    end
`else
    // Upper immediate bits are simply truncated when range checking is off.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_q[31:21];
    assign imm_ok        = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = start_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (req_valid) begin
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                if (cls_illegal || !imm_ok) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdata_d = enc_word;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                ptr_d = ptr_q + 1'b1;
                if (count_q != C_COUNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cls_q <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            f3_q  <= '0;
            f7_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            cls_q <= req_class;
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            f3_q  <= funct3;
            f7_q  <= funct7;
            imm_q <= imm;
        end
    end

    // Write strobe is decoded from state so an async reset removes it at once.
    assign imem_we    = (state_q == S_WR);
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
